// File: rtl/cursor_grid_nav.sv
`default_nettype none
// ============================================================================
// Module   : cursor_grid_nav
// Purpose  : Turns two ADC joystick axes into a cursor position on a
//            GRID_W x GRID_H board. Has dead-zone thresholds and diagonal
//            moves. A held deflection first steps after REPEAT_DELAY cycles,
//            then steps again every REPEAT_RATE cycles.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            enable          - navigation enable (0 freezes the cursor)
//            Xdata, Ydata    - raw axis samples (low = left/up, high = right/down)
//            position        - linear cell index row*GRID_W + col
//            row, col        - current cursor coordinates
//            moved           - one-cycle pulse on each accepted step
// Options  : CURSOR_WRAP_EN  - when defined, a step past an edge wraps to the
//                              opposite edge instead of saturating
// Revision : 1.0 - initial release
// ============================================================================
module cursor_grid_nav #(
  parameter int ADC_W        = 10,
  parameter int GRID_W       = 3,
  parameter int GRID_H       = 3,
  parameter int POS_W        = 4,
  parameter int LOW_TH       = 250,
  parameter int HIGH_TH      = 750,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] Xdata,
  input  logic [ADC_W-1:0] Ydata,
  output logic [POS_W-1:0] position,
  output logic [3:0]       row,
  output logic [3:0]       col,
  output logic             moved
);

  localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_DELAY_LAST = c_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_RATE_LAST  = c_CNT_W'(REPEAT_RATE - 1);

  localparam logic [ADC_W-1:0] c_LOW_TH  = ADC_W'(LOW_TH);
  localparam logic [ADC_W-1:0] c_HIGH_TH = ADC_W'(HIGH_TH);
  // The sample registers reset to a value inside the dead zone. This keeps
  // the first decode after reset release from reading as a deflection.
  localparam logic [ADC_W-1:0] c_CENTRE  = ADC_W'((LOW_TH + HIGH_TH) / 2);

  localparam logic [3:0] c_COL_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] c_ROW_MAX = 4'(GRID_H - 1);
  localparam logic [3:0] c_COL_RST = 4'((GRID_W - 1) / 2);
  localparam logic [3:0] c_ROW_RST = 4'((GRID_H - 1) / 2);
  localparam logic [POS_W-1:0] c_POS_RST = POS_W'(((GRID_H - 1) / 2) * GRID_W + (GRID_W - 1) / 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Direction encoding per axis: 2'b11 = -1, 2'b01 = +1, 2'b00 = centred
  localparam logic [1:0] c_NEG = 2'b11;
  localparam logic [1:0] c_POS = 2'b01;
  localparam logic [1:0] c_ZERO = 2'b00;

  logic [ADC_W-1:0]   xs_q, ys_q;
  logic [1:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         last_dir_q, last_dir_d;
  logic [3:0]         row_q, row_d, col_q, col_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               moved_q, moved_d;

  logic [1:0]         w_dx, w_dy;
  logic [3:0]         w_dir;
  logic               w_step;
  logic [c_CNT_W-1:0] w_limit;

  // Move one axis by d, clamping or wrapping at 0 and maxv
  function automatic logic [3:0] f_axis(input logic [3:0] cur,
                                        input logic [1:0] d,
                                        input logic [3:0] maxv);
    logic [3:0] nxt;
    nxt = cur;
    if (d == c_POS) begin
      if (cur == maxv) begin
`ifdef CURSOR_WRAP_EN
        nxt = 4'd0;
`else
        nxt = cur;
`endif
      end else begin
        nxt = cur + 4'd1;
      end
    end else if (d == c_NEG) begin
      if (cur == 4'd0) begin
`ifdef CURSOR_WRAP_EN
        nxt = maxv;
`else
        nxt = cur;
`endif
      end else begin
        nxt = cur - 4'd1;
      end
    end
    return nxt;
  endfunction

  // Dead-zone decode. A sample equal to a threshold counts as centred.
  always_comb begin
    w_dx = c_ZERO;
    if (xs_q < c_LOW_TH)       w_dx = c_NEG;
    else if (xs_q > c_HIGH_TH) w_dx = c_POS;
    w_dy = c_ZERO;
    if (ys_q < c_LOW_TH)       w_dy = c_NEG;
    else if (ys_q > c_HIGH_TH) w_dy = c_POS;
  end

  assign w_dir   = {w_dx, w_dy};
  assign w_limit = (state_q == S_REPEAT) ? c_RATE_LAST : c_DELAY_LAST;

  // Hold/auto-repeat sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dir_d = last_dir_q;
    w_step     = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_dir != 4'd0) begin
            w_step     = 1'b1;
            last_dir_d = w_dir;
            cnt_d      = '0;
            state_d    = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (w_dir == 4'd0) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (w_dir != last_dir_q) begin
            // A new direction steps at once and restarts the initial delay
            w_step     = 1'b1;
            last_dir_d = w_dir;
            cnt_d      = '0;
            state_d    = S_HOLD;
          end else if (cnt_q == w_limit) begin
            w_step  = 1'b1;
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Position update. Both axes move in the same cycle, so diagonal moves
  // take a single step.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (w_step) begin
      col_d = f_axis(col_q, w_dx, c_COL_MAX);
      row_d = f_axis(row_q, w_dy, c_ROW_MAX);
    end
    pos_d = POS_W'(int'(row_d) * GRID_W + int'(col_d));
`ifdef CURSOR_WRAP_EN
    moved_d = w_step;
`else
    // A step blocked on both axes is not reported
    moved_d = w_step && ((col_d != col_q) || (row_d != row_q));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q       <= c_CENTRE;
      ys_q       <= c_CENTRE;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dir_q <= 4'd0;
      row_q      <= c_ROW_RST;
      col_q      <= c_COL_RST;
      pos_q      <= c_POS_RST;
      moved_q    <= 1'b0;
    end else begin
      xs_q       <= Xdata;
      ys_q       <= Ydata;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pos_q      <= pos_d;
      moved_q    <= moved_d;
    end
  end

  assign position = pos_q;
  assign row      = row_q;
  assign col      = col_q;
  assign moved    = moved_q;

endmodule
`default_nettype wire
